// File: rtl/test_pattern_gen_if.sv
// rtl/test_pattern_gen_if.sv - pixel stream bundle between the pattern source and its consumer
interface test_pattern_gen_if #(
    parameter int PIXEL_BITS = 4
) ();
    logic                        valid_o;
    logic                        ready_i;
    logic [2:0][PIXEL_BITS-1:0]  data_o;
    logic                        sof_o;
    logic                        eol_o;
    logic                        eof_o;

    modport master (
        output valid_o,
        output data_o,
        output sof_o,
        output eol_o,
        output eof_o,
        input  ready_i
    );

    modport slave (
        input  valid_o,
        input  data_o,
        input  sof_o,
        input  eol_o,
        input  eof_o,
        output ready_i
    );
endinterface

// File: rtl/test_pattern_gen.sv
// rtl/test_pattern_gen.sv - raster test-pattern source (bars/checker/ramp/solid)
// Optional per-frame horizontal scroll is built when PATGEN_SCROLL_EN is defined.
module test_pattern_gen #(
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int PIXEL_BITS  = 4,
    parameter int CHECK_LOG2  = 5,
    parameter int SCROLL_STEP = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic [1:0]              mode_i,
    input  logic [3*PIXEL_BITS-1:0] color_i,
    test_pattern_gen_if.master      vid
);
    localparam int XW     = $clog2(WIDTH);
    localparam int YW     = $clog2(HEIGHT);
    localparam int BAR_W  = WIDTH / 8;
    localparam int RAMP_K = (1 << (16 + PIXEL_BITS)) / WIDTH;
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    logic                    valid_q;
    logic [XW-1:0]           x_q, x_d;
    logic [YW-1:0]           y_q, y_d;
    logic [1:0]              mode_q, mode_d;
    logic [3*PIXEL_BITS-1:0] color_q, color_d;

    logic          xfer, last_x, last_y, eof_pix;
    logic [XW-1:0] xe;

    assign xfer    = valid_q & vid.ready_i;
    assign last_x  = (x_q == X_LAST);
    assign last_y  = (y_q == Y_LAST);
    assign eof_pix = last_x & last_y;

    // Mode and colour are only sampled as the last pixel of a frame leaves,
    // so a frame is never rendered in two different patterns.
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        mode_d  = mode_q;
        color_d = color_q;
        if (xfer) begin
            if (last_x) begin
                x_d = '0;
                y_d = last_y ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
            if (eof_pix) begin
                mode_d  = mode_i;
                color_d = color_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            valid_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            mode_q  <= 2'd0;
            color_q <= '0;
        end else begin
            valid_q <= 1'b1;
            x_q     <= x_d;
            y_q     <= y_d;
            mode_q  <= mode_d;
            color_q <= color_d;
        end
    end

`ifdef PATGEN_SCROLL_EN
    localparam logic [XW:0] W_EXT = (XW + 1)'(WIDTH);

    logic [XW-1:0] offset_q, offset_d;
    logic [XW:0]   off_sum, xe_sum;

    always_comb begin
        off_sum  = {1'b0, offset_q} + (XW + 1)'(SCROLL_STEP);
        offset_d = offset_q;
        if (xfer && eof_pix) begin
            offset_d = (off_sum >= W_EXT) ? XW'(off_sum - W_EXT) : off_sum[XW-1:0];
        end
        xe_sum = {1'b0, x_q} + {1'b0, offset_q};
        xe     = (xe_sum >= W_EXT) ? XW'(xe_sum - W_EXT) : xe_sum[XW-1:0];
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            offset_q <= '0;
        end else begin
            offset_q <= offset_d;
        end
    end
`else
    assign xe = x_q;
`endif

    logic [2:0]                 bar_idx;
    logic                       checker_white;
    logic [PIXEL_BITS-1:0]      ramp_px;
    logic [2:0][PIXEL_BITS-1:0] pix;

    always_comb begin
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (xe >= XW'(k * BAR_W)) bar_idx = bar_idx + 3'd1;
        end
    end

    assign checker_white = ~(xe[CHECK_LOG2] ^ y_q[CHECK_LOG2]);
    assign ramp_px       = PIXEL_BITS'((32'(xe) * 32'(RAMP_K)) >> 16);

    // Bar order white..black maps to r=~idx[1], g=~idx[2], b=~idx[0].
    always_comb begin
        pix = '0;
        case (mode_q)
            2'd0: begin
                pix[0] = {PIXEL_BITS{~bar_idx[1]}};
                pix[1] = {PIXEL_BITS{~bar_idx[2]}};
                pix[2] = {PIXEL_BITS{~bar_idx[0]}};
            end
            2'd1: pix = {3{{PIXEL_BITS{checker_white}}}};
            2'd2: pix = {3{ramp_px}};
            default: begin
                pix[0] = color_q[2*PIXEL_BITS +: PIXEL_BITS];
                pix[1] = color_q[PIXEL_BITS +: PIXEL_BITS];
                pix[2] = color_q[0 +: PIXEL_BITS];
            end
        endcase
    end

    assign vid.valid_o = valid_q;
    assign vid.data_o  = valid_q ? pix : '0;
    assign vid.sof_o   = valid_q & (x_q == '0) & (y_q == '0);
    assign vid.eol_o   = valid_q & last_x;
    assign vid.eof_o   = valid_q & eof_pix;
endmodule

// File: tb/tb_test_pattern_gen.sv
// tb/tb_test_pattern_gen.sv - directed bench for test_pattern_gen (640x8 raster, 4x4 checker squares)
module tb_test_pattern_gen;
    localparam int WIDTH       = 640;
    localparam int HEIGHT      = 8;
    localparam int PIXEL_BITS  = 4;
    localparam int CHECK_LOG2  = 2;
    localparam int SCROLL_STEP = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [11:0] color = 12'h000;

    int checks = 0;
    int passed = 0;
    int cur_x = 0;
    int cur_y = 0;
    int frame = 1;

    logic [11:0] obs;

    test_pattern_gen_if #(.PIXEL_BITS(PIXEL_BITS)) vid ();

    test_pattern_gen #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .PIXEL_BITS(PIXEL_BITS),
        .CHECK_LOG2(CHECK_LOG2), .SCROLL_STEP(SCROLL_STEP)
    ) dut (
        .clk_i(clk), .reset_ni(rst_n), .mode_i(mode), .color_i(color), .vid(vid)
    );

    always #5 clk = ~clk;

    assign obs = vid.data_o;

    function automatic int xe_of(int x);
        int s;
`ifdef PATGEN_SCROLL_EN
        s = x + ((frame - 1) * SCROLL_STEP) % WIDTH;
`else
        s = x;
`endif
        if (s >= WIDTH) s -= WIDTH;
        return s;
    endfunction

    // Expected value packed as {blue,green,red}, matching data_o[2..0].
    function automatic logic [11:0] bars_exp(int xe);
        case (xe / 80)
            0: return 12'hFFF;
            1: return 12'h0FF;
            2: return 12'hFF0;
            3: return 12'h0F0;
            4: return 12'hF0F;
            5: return 12'h00F;
            6: return 12'hF00;
            default: return 12'h000;
        endcase
    endfunction

    task automatic step();
        @(negedge clk);
        cur_x++;
        if (cur_x == WIDTH) begin
            cur_x = 0;
            cur_y++;
            if (cur_y == HEIGHT) begin
                cur_y = 0;
                frame++;
            end
        end
    endtask

    task automatic goto_px(int tx, int ty);
        int n;
        n = (ty * WIDTH + tx) - (cur_y * WIDTH + cur_x);
        if (n < 0) n += WIDTH * HEIGHT;
        repeat (n) step();
    endtask

    task automatic test_reset();
        vid.ready_i = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (vid.valid_o !== 1'b0) $display("FAIL reset_valid got=%b want=0", vid.valid_o); else passed++;
        checks++; if ({vid.sof_o, vid.eol_o, vid.eof_o} !== 3'b000) $display("FAIL reset_flags got=%b want=000", {vid.sof_o, vid.eol_o, vid.eof_o}); else passed++;
        checks++; if (obs !== 12'h000) $display("FAIL reset_data got=%h want=000", obs); else passed++;
        rst_n = 1'b1;
        @(negedge clk);
        cur_x = 0; cur_y = 0; frame = 1;
        checks++; if (vid.valid_o !== 1'b1) $display("FAIL first_valid got=%b want=1", vid.valid_o); else passed++;
        checks++; if (vid.sof_o !== 1'b1) $display("FAIL first_sof got=%b want=1", vid.sof_o); else passed++;
        checks++; if (obs !== 12'hFFF) $display("FAIL first_data got=%h want=FFF", obs); else passed++;
    endtask

    task automatic test_bars();
        step();
        checks++; if (vid.sof_o !== 1'b0) $display("FAIL sof_x1 got=%b want=0", vid.sof_o); else passed++;
        goto_px(80, 0);
        checks++; if (obs !== 12'h0FF) $display("FAIL bars_x80 got=%h want=0FF", obs); else passed++;
        goto_px(480, 0);
        checks++; if (obs !== 12'hF00) $display("FAIL bars_x480 got=%h want=F00", obs); else passed++;
        goto_px(560, 0);
        checks++; if (obs !== 12'h000) $display("FAIL bars_x560 got=%h want=000", obs); else passed++;
        goto_px(638, 0);
        checks++; if (vid.eol_o !== 1'b0) $display("FAIL eol_x638 got=%b want=0", vid.eol_o); else passed++;
        step();
        checks++; if ({vid.eol_o, vid.eof_o} !== 2'b10) $display("FAIL flags_x639 got=%b want=10", {vid.eol_o, vid.eof_o}); else passed++;
    endtask

    task automatic test_backpressure();
        goto_px(79, 3);
        checks++; if (obs !== 12'hFFF) $display("FAIL bp_before got=%h want=FFF", obs); else passed++;
        vid.ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (obs !== 12'hFFF || {vid.sof_o, vid.eol_o, vid.eof_o} !== 3'b000 || vid.valid_o !== 1'b1)
                $display("FAIL bp_hold%0d got=%h/%b want=FFF/000", i, obs, {vid.sof_o, vid.eol_o, vid.eof_o}); else passed++;
        end
        vid.ready_i = 1'b1;
        step();
        checks++; if (obs !== 12'h0FF) $display("FAIL bp_next got=%h want=0FF", obs); else passed++;
        goto_px(159, 3);
        checks++; if (obs !== 12'h0FF) $display("FAIL bp_x159 got=%h want=0FF", obs); else passed++;
        step();
        checks++; if (obs !== 12'hFF0) $display("FAIL bp_x160 got=%h want=FF0", obs); else passed++;
    endtask

    task automatic test_frame_end();
        goto_px(639, 7);
        checks++; if ({vid.eol_o, vid.eof_o} !== 2'b11) $display("FAIL eof_flags got=%b want=11", {vid.eol_o, vid.eof_o}); else passed++;
        checks++; if (obs !== 12'h000) $display("FAIL eof_data got=%h want=000", obs); else passed++;
        step();
        checks++; if ({vid.sof_o, vid.eof_o} !== 2'b10) $display("FAIL wrap_flags got=%b want=10", {vid.sof_o, vid.eof_o}); else passed++;
        checks++; if (obs !== 12'hFFF) $display("FAIL frame2_x0 got=%h want=FFF", obs); else passed++;
    endtask

    task automatic test_scroll();
        logic [11:0] want;
`ifdef PATGEN_SCROLL_EN
        want = 12'h0FF;
`else
        want = 12'hFFF;
`endif
        goto_px(76, 0);
        checks++; if (obs !== want) $display("FAIL scroll_x76 got=%h want=%h", obs, want); else passed++;
    endtask

    task automatic test_mode_switch();
        goto_px(10, 5);
        mode = 2'd1;
        goto_px(600, 6);
        checks++; if (obs !== 12'h000) $display("FAIL midframe_bars got=%h want=000", obs); else passed++;
        goto_px(639, 7);
        checks++; if (obs !== bars_exp(xe_of(639))) $display("FAIL eof_still_bars got=%h want=%h", obs, bars_exp(xe_of(639))); else passed++;
        step();
        checks++; if (obs !== 12'hFFF) $display("FAIL chk_0_0 got=%h want=FFF", obs); else passed++;
        mode = 2'd2;
        goto_px(4, 0);
        checks++; if (obs !== 12'h000) $display("FAIL chk_4_0 got=%h want=000", obs); else passed++;
        goto_px(4, 4);
        checks++; if (obs !== 12'hFFF) $display("FAIL chk_4_4 got=%h want=FFF", obs); else passed++;
    endtask

    task automatic test_ramp();
        logic [11:0] w0, w40, w41, w639;
`ifdef PATGEN_SCROLL_EN
        w0 = 12'h000; w40 = 12'h111; w41 = 12'h111; w639 = 12'h000;
`else
        w0 = 12'h000; w40 = 12'h000; w41 = 12'h111; w639 = 12'hFFF;
`endif
        goto_px(639, 7);
        step();
        checks++; if (obs !== w0) $display("FAIL ramp_x0 got=%h want=%h", obs, w0); else passed++;
        mode = 2'd3;
        color = 12'hA53;
        goto_px(40, 0);
        checks++; if (obs !== w40) $display("FAIL ramp_x40 got=%h want=%h", obs, w40); else passed++;
        step();
        checks++; if (obs !== w41) $display("FAIL ramp_x41 got=%h want=%h", obs, w41); else passed++;
        goto_px(639, 0);
        checks++; if (obs !== w639) $display("FAIL ramp_x639 got=%h want=%h", obs, w639); else passed++;
    endtask

    task automatic test_solid();
        goto_px(639, 7);
        step();
        color = 12'h000;
        checks++; if (obs !== 12'h35A) $display("FAIL solid_0_0 got=%h want=35A", obs); else passed++;
        goto_px(333, 4);
        checks++; if (obs !== 12'h35A) $display("FAIL solid_333_4 got=%h want=35A", obs); else passed++;
        goto_px(639, 7);
        checks++; if (obs !== 12'h35A || vid.eof_o !== 1'b1) $display("FAIL solid_eof got=%h/%b want=35A/1", obs, vid.eof_o); else passed++;
    endtask

    task automatic test_async_reset();
        step();
        mode = 2'd1;
        goto_px(300, 2);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (vid.valid_o !== 1'b0 || obs !== 12'h000) $display("FAIL async_reset got=%b/%h want=0/000", vid.valid_o, obs); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cur_x = 0; cur_y = 0; frame = 1;
        checks++; if (vid.valid_o !== 1'b1 || vid.sof_o !== 1'b1) $display("FAIL restart_flags got=%b%b want=11", vid.valid_o, vid.sof_o); else passed++;
        goto_px(4, 0);
        checks++; if (obs !== 12'hFFF) $display("FAIL restart_bars got=%h want=FFF", obs); else passed++;
    endtask

    initial begin
        vid.ready_i = 1'b0;
        test_reset();
        test_bars();
        test_backpressure();
        test_frame_end();
        test_scroll();
        test_mode_switch();
        test_ramp();
        test_solid();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
